// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit between the core datapath and a word-addressed
// data memory with a combinational read port and a whole-word write port.
//
// Byte and halfword stores become read-modify-write sequences; loads pick the
// addressed lane out of the memory word and sign- or zero-extend it.
// Misaligned accesses are answered with an error and never reach the memory.
// Only one request is in flight at a time.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_size             00 byte, 01 half, 10/11 word
//   req_signed           load extension: 1 = sign, 0 = zero
//   req_addr             byte address
//   req_wdata            right-aligned store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load data (0 for stores and errors)
//   rsp_err              misaligned access
//   mem_we/mem_a/mem_wd  memory write enable, word-aligned address, write data
//   mem_rd               memory read data, combinational from mem_a
module lsu_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // Lane extraction plus sign/zero extension for loads.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] lane);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = lane[0];
      default: m = (lane != 2'b00);
    endcase
    return m;
  endfunction

  state_t              state_q;
  logic                rdy_q, vld_q, err_q, mem_we_q;
  logic [31:0]         rdata_q, buf_q, wdata_q;
  logic                we_q, sgn_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;

  logic [31:0]         ld_data_d, merged_d;
  logic                mis_d;

  assign ld_data_d = load_extract(mem_rd, size_q, addr_q[1:0], sgn_q);
  assign merged_d  = store_merge(mem_rd, wdata_q, size_q, addr_q[1:0]);
  assign mis_d     = misaligned(req_size, req_addr[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b1;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mem_we_q <= 1'b0;
      buf_q    <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdy_q   <= 1'b0;
            if (mis_d) begin
              state_q <= RESP;
              vld_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (!req_we || !req_size[1]) begin
              // Loads and sub-word stores both need the current memory word.
              state_q <= READ;
            end else begin
              // Full-word store skips the read; the write word is the data itself.
              state_q  <= WRITE;
              mem_we_q <= 1'b1;
              buf_q    <= req_wdata;
            end
          end
        end
        READ: begin
          if (!we_q) begin
            buf_q   <= mem_rd;
            rdata_q <= ld_data_d;
            err_q   <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            buf_q    <= merged_d;
            mem_we_q <= 1'b1;
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          mem_we_q <= 1'b0;
          rdata_q  <= '0;
          err_q    <= 1'b0;
          vld_q    <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_we    = mem_we_q;
  // The latched address is always driven, so mem_a is known even when idle.
  assign mem_a     = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wd    = buf_q;

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int total = 0;
  int bad = 0;
  int wcount = 0;

  // Memory: 256 words, combinational read, write on rising edge.
  logic [31:0] mem [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [31:0] pl_d = '0;

  // Reference model: byte-addressed memory image.
  logic [7:0]  refm [0:1023];

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_a[9:2]] <= mem_wd;
    else if (pl_we) mem[pl_a] <= pl_d;
  end

  always @(negedge clk) if (mem_we) wcount++;

  lsu_rmw #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_we(mem_we),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int w = int'(a) & ~3;
    return {refm[w+3], refm[w+2], refm[w+1], refm[w]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sg,
                                           input logic [31:0] a);
    int n = nbytes(sz);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(refm[int'(a) + i]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void ref_apply(input bit we, input logic [1:0] sz,
                                    input logic [31:0] a, input logic [31:0] wd);
    int n = nbytes(sz);
    if (we && !ref_mis(sz, a))
      for (int i = 0; i < n; i++) refm[int'(a) + i] = wd[8*i +: 8];
  endfunction

  function automatic int exp_lat(input bit we, input logic [1:0] sz,
                                 input logic [31:0] a);
    if (ref_mis(sz, a)) return 1;
    if (!we || sz[1]) return 2;
    return 3;
  endfunction

  // Presents one request, waits for the response (bounded), holds rsp_ready
  // low for 'hold' cycles, then takes it.
  task automatic run_req(input bit we, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int hold, output int lat, output logic [31:0] rd,
                         output logic err, output int nwr, output logic acc);
    int w0 = wcount;
    @(negedge clk);
    acc = req_ready;
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    err = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    nwr = wcount - w0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pl_we = 1'b1; pl_a = 8'(i); pl_d = (i == 4) ? 32'h8899AABB : $urandom;
      for (int b = 0; b < 4; b++) refm[4*i+b] = pl_d[8*b +: 8];
    end
    @(negedge clk);
    pl_we = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin bad++; $display("FAIL reset_release got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid, req_ready); end
  endtask

  task automatic test_loads();
    int lat, nwr; logic [31:0] rd; logic err, acc;
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, lat, rd, err, nwr, acc);
    total++; if (rd !== 32'hFFFFFF88) begin bad++; $display("FAIL lb_signed rdata got=%h want=ffffff88", rd); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL lb_signed err got=%b want=0", err); end
    total++; if (lat != 2) begin bad++; $display("FAIL lb_signed latency got=%0d want=2", lat); end
    total++; if (nwr != 0) begin bad++; $display("FAIL lb_signed writes got=%0d want=0", nwr); end
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, lat, rd, err, nwr, acc);
    total++; if (rd !== 32'h00008899) begin bad++; $display("FAIL lh_unsigned rdata got=%h want=00008899", rd); end
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, lat, rd, err, nwr, acc);
    total++; if (rd !== 32'h8899AABB) begin bad++; $display("FAIL lw rdata got=%h want=8899aabb", rd); end
    total++; if (lat != 2) begin bad++; $display("FAIL lw latency got=%0d want=2", lat); end
  endtask

  task automatic test_store_byte();
    int lat, nwr; logic [31:0] rd; logic err, acc;
    run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234565C, 0, lat, rd, err, nwr, acc);
    ref_apply(1'b1, 2'd0, 32'h11, 32'h1234565C);
    total++; if (nwr != 1) begin bad++; $display("FAIL sb writes got=%0d want=1", nwr); end
    total++; if (mem[4] !== 32'h88995CBB) begin bad++; $display("FAIL sb memword got=%h want=88995cbb", mem[4]); end
    total++; if (lat != 3) begin bad++; $display("FAIL sb latency got=%0d want=3", lat); end
    total++; if (rd !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL sb rsp got rdata=%h err=%b want 0/0", rd, err); end
  endtask

  task automatic test_misaligned();
    int lat, nwr; logic [31:0] rd; logic err, acc;
    run_req(1'b0, 2'd2, 1'b1, 32'h12, 32'h0, 0, lat, rd, err, nwr, acc);
    total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mis_lw rsp got err=%b rdata=%h want 1/0", err, rd); end
    total++; if (lat != 1) begin bad++; $display("FAIL mis_lw latency got=%0d want=1", lat); end
    total++; if (nwr != 0) begin bad++; $display("FAIL mis_lw writes got=%0d want=0", nwr); end
    run_req(1'b1, 2'd1, 1'b0, 32'h15, 32'hFFFF1357, 0, lat, rd, err, nwr, acc);
    total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mis_sh rsp got err=%b rdata=%h want 1/0", err, rd); end
    total++; if (lat != 1) begin bad++; $display("FAIL mis_sh latency got=%0d want=1", lat); end
    total++; if (nwr != 0) begin bad++; $display("FAIL mis_sh writes got=%0d want=0", nwr); end
    total++; if (mem[5] !== ref_word(32'h14)) begin bad++; $display("FAIL mis_sh memword got=%h want=%h", mem[5], ref_word(32'h14)); end
  endtask

  task automatic test_backpressure();
    int lat; int w0 = wcount; logic [31:0] held;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    total++; if (lat != 2) begin bad++; $display("FAIL bp latency got=%0d want=2", lat); end
    held = rsp_rdata;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== held)
        begin bad++; $display("FAIL bp hold%0d got vld=%b rdy=%b rdata=%h want vld=1 rdy=0 rdata=%h", i, rsp_valid, req_ready, rsp_rdata, held); end
      req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10; req_valid = 1'b1;
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    ref_apply(1'b1, 2'd2, 32'h20, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
        begin bad++; $display("FAIL bp after%0d got vld=%b rdy=%b want vld=0 rdy=1", i, rsp_valid, req_ready); end
    end
    total++; if (mem[8] !== 32'hDEADBEEF) begin bad++; $display("FAIL bp memword got=%h want=deadbeef", mem[8]); end
    total++; if (wcount - w0 != 1) begin bad++; $display("FAIL bp writes got=%0d want=1", wcount - w0); end
  endtask

  task automatic test_reset_mid();
    int lat, nwr; int w0 = wcount; logic [31:0] rd; logic err, acc;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0000CAFE;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || mem_we !== 1'b0)
      begin bad++; $display("FAIL midreset outputs got rdy=%b vld=%b rdata=%h err=%b we=%b want 1/0/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (wcount != w0) begin bad++; $display("FAIL midreset writes got=%0d want=0", wcount - w0); end
    total++; if (mem[4] !== ref_word(32'h10)) begin bad++; $display("FAIL midreset memword got=%h want=%h", mem[4], ref_word(32'h10)); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset lost_rsp got=%b want=0", rsp_valid); end
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, lat, rd, err, nwr, acc);
    total++; if (rd !== ref_word(32'h10) || lat != 2 || err !== 1'b0)
      begin bad++; $display("FAIL midreset reload got rdata=%h lat=%0d err=%b want rdata=%h lat=2 err=0", rd, lat, err, ref_word(32'h10)); end
  endtask

  task automatic test_random();
    int lat, nwr, hold; logic [31:0] rd, a, wd, exp; logic err, acc; bit we, sg, mis;
    logic [1:0] sz;
    for (int it = 0; it < 60; it++) begin
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 2) != 0) a = a & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
      wd = $urandom;
      hold = $urandom_range(0, 2);
      mis = ref_mis(sz, a);
      exp = (we || mis) ? 32'h0 : ref_load(sz, sg, a);
      run_req(we, sz, sg, a, wd, hold, lat, rd, err, nwr, acc);
      ref_apply(we, sz, a, wd);
      total++;
      if (acc !== 1'b1 || rd !== exp || err !== mis || lat != exp_lat(we, sz, a) ||
          nwr != ((we && !mis) ? 1 : 0) || mem[a[9:2]] !== ref_word(a)) begin
        bad++;
        $display("FAIL rand%0d we=%0d sz=%0d a=%h got rdata=%h err=%b lat=%0d wr=%0d mem=%h rdy=%b want rdata=%h err=%b lat=%0d mem=%h",
                 it, we, sz, a, rd, err, lat, nwr, mem[a[9:2]], acc, exp, mis, exp_lat(we, sz, a), ref_word(a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_byte();
    test_misaligned();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
